alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle MIPS-lite ALU. It keeps the 3-bit ALU-control encoding and the zero/overflow/negative flags, and adds:
- iterative unsigned multiply and divide;
- overflow-correct signed set-on-less-than;
- a second result word;
- valid/ready handshakes on both sides.

It sits between the decode/register-read stage and writeback of the multi-cycle datapath. The controller stalls on `in_ready` / `out_valid`.

---
 rtl/alu_mc_pkg.sv | 12 +
 rtl/alu_mc_if.sv | 10 +
 rtl/alu_mc_iter_core.sv | 38 +++
 rtl/alu_mc.sv | 73 +++++++
 tb/tb_alu_mc.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mc_pkg.sv
// alu_pkg: ALU control codes and FSM state type shared by alu_mc and its bench
package alu_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_DIVU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response valid-ready bundle between datapath controller and alu_mc
interface alu_mc_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, zout, vout, nout;
  logic [WIDTH-1:0] a, b, result, result_hi;
  logic [2:0] gin;
  modport master(output in_valid, a, b, gin, out_ready,
                 input in_ready, out_valid, result, result_hi, zout, vout, nout);
  modport slave(input in_valid, a, b, gin, out_ready,
                output in_ready, out_valid, result, result_hi, zout, vout, nout);
endinterface

// File: rtl/alu_mc_iter_core.sv
// alu_iter_core: shift-add multiply / restoring divide datapath, one step per enabled edge
module alu_iter_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_d_o,
  output logic [WIDTH-1:0] lo_d_o
);
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [WIDTH:0] sum, rem_t, rem_s;
  logic ge;
  // hi/lo hold product halves for MUL and remainder/quotient for DIVU
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem_t = {hi_q, lo_q[WIDTH-1]};
    rem_s = rem_t - {1'b0, m_q};
    ge = rem_t >= {1'b0, m_q};
    hi_d_o = div_i ? (ge ? rem_s[WIDTH-1:0] : rem_t[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d_o = div_i ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_i;
      m_q <= b_i;
    end else if (step_i) begin
      hi_q <= hi_d_o;
      lo_q <= lo_d_o;
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS-lite ALU with iterative MUL/DIVU, flags and valid/ready handshakes
module alu_mc import alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  alu_mc_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  alu_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic div_q, dz_q, z_q, v_q, n_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic accept, iter_op, v_add, v_sub, sc_v;
  logic [WIDTH-1:0] sum, diff, sc_res, core_hi, core_lo;
  assign bus.in_ready = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign iter_op = bus.gin == ALU_MUL || bus.gin == ALU_DIVU;
  always_comb begin
    sum = bus.a + bus.b;
    diff = bus.a + ~bus.b + WIDTH'(1);
    v_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    v_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    sc_res = bus.gin == ALU_AND ? bus.a & bus.b :
             bus.gin == ALU_OR  ? bus.a | bus.b :
             bus.gin == ALU_ADD ? sum :
             bus.gin == ALU_NOR ? ~(bus.a | bus.b) :
             bus.gin == ALU_SUB ? diff :
             {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ v_sub};
    sc_v = bus.gin == ALU_ADD ? v_add : bus.gin == ALU_SUB ? v_sub : 1'b0;
  end
  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst_n(rst_n), .load_i(accept && iter_op), .step_i(state_q == BUSY),
    .div_i(div_q), .a_i(bus.a), .b_i(bus.b), .hi_d_o(core_hi), .lo_d_o(core_lo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      res_q <= '0;
      hi_q <= '0;
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else if (accept && iter_op) begin
      state_q <= BUSY;
      cnt_q <= CW'(WIDTH - 1);
      div_q <= bus.gin == ALU_DIVU;
      dz_q <= bus.b == '0;
    end else if (accept) begin
      state_q <= DONE;
      res_q <= sc_res;
      hi_q <= '0;
      z_q <= ~|sc_res;
      v_q <= sc_v;
      n_q <= sc_res[WIDTH-1];
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_q <= DONE;
        res_q <= core_lo;
        hi_q <= core_hi;
        z_q <= ~|core_lo;
        v_q <= div_q ? dz_q : |core_hi;
        n_q <= core_lo[WIDTH-1];
      end else cnt_q <= cnt_q - CW'(1);
    end else if (state_q == DONE && bus.out_ready) state_q <= IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result = res_q;
  assign bus.result_hi = hi_q;
  assign bus.zout = z_q;
  assign bus.vout = v_q;
  assign bus.nout = n_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_alu_mc;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_mc_if #(.WIDTH(W)) bus();
  alu_mc #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int passed = 0, total = 0;
  typedef struct packed { logic [W-1:0] r, hi; logic z, v, n; } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic res_t ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t o;
    longint sa, sb, s;
    logic [63:0] p;
    o = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_AND: o.r = a & b;
      ALU_OR:  o.r = a | b;
      ALU_NOR: o.r = ~(a | b);
      ALU_ADD: begin s = sa + sb; o.r = W'(s); o.v = s != longint'($signed(o.r)); end
      ALU_SUB: begin s = sa - sb; o.r = W'(s); o.v = s != longint'($signed(o.r)); end
      ALU_SLT: o.r = (sa < sb) ? W'(1) : W'(0);
      ALU_MUL: begin p = 64'(a) * 64'(b); o.r = p[W-1:0]; o.hi = p[63:W]; o.v = o.hi != 0; end
      ALU_DIVU: if (b == 0) begin o.r = '1; o.hi = a; o.v = 1'b1; end
                else begin o.r = a / b; o.hi = a % b; end
      default: o = '0;
    endcase
    o.z = o.r == 0;
    o.n = o.r[W-1];
    return o;
  endfunction

  // model: idle / counting down an iterative op / holding a result
  res_t cur = '0, pend = '0;
  bit m_valid = 1'b0;
  int m_wait = 0;
  logic exp_ready;
  assign exp_ready = (!m_valid && m_wait == 0) || (m_valid && bus.out_ready);
  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    rdy = (!m_valid && m_wait == 0) || (m_valid && bus.out_ready);
    if (!rst_n) begin
      cur = '0;
      m_valid = 1'b0;
      m_wait = 0;
    end else if (bus.in_valid && rdy) begin
      if (bus.gin == ALU_MUL || bus.gin == ALU_DIVU) begin
        pend = ref_op(bus.gin, bus.a, bus.b);
        m_wait = W;
        m_valid = 1'b0;
      end else begin
        cur = ref_op(bus.gin, bus.a, bus.b);
        m_valid = 1'b1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        cur = pend;
        m_valid = 1'b1;
      end
    end else if (m_valid && bus.out_ready) m_valid = 1'b0;
  end

  always @(negedge clk) if (rst_n) begin
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, m_valid);
    chk("result", bus.result, cur.r);
    chk("result_hi", bus.result_hi, cur.hi);
    chk("zout", bus.zout, cur.z);
    chk("vout", bus.vout, cur.v);
    chk("nout", bus.nout, cur.n);
  end

  task automatic op(input logic [2:0] g, input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                    input logic [W-1:0] er, input logic [W-1:0] eh, input logic ev, input logic ez,
                    input logic en, input string nm);
    bus.in_valid = 1'b1;
    bus.gin = g;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk({nm, "_early_valid"}, bus.out_valid, 1'b0);
      chk({nm, "_busy_ready"}, bus.in_ready, 1'b0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_hi"}, bus.result_hi, eh);
    chk({nm, "_v"}, bus.vout, ev);
    chk({nm, "_z"}, bus.zout, ez);
    chk({nm, "_n"}, bus.nout, en);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 7)
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    res_t pin;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.gin = ALU_AND;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    pin = ref_op(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("model_slt_ovf", pin.r, 32'h0);
    pin = ref_op(ALU_DIVU, 32'd100, 32'd7);
    chk("model_divu_rem", pin.hi, 32'd2);
    op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1, "add_ovf");
    op(ALU_SUB, 32'd5, 32'd5, 1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "sub_zero");
    op(ALU_SLT, 32'hFFFF_FFFB, 32'd3, 1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, "slt_neg");
    op(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "slt_ovf");
    op(ALU_NOR, 32'h0, 32'h0, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, "nor");
    op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 32'h1, 1'b1, 1'b0, 1'b1, "mul");
    op(ALU_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, "divu");
    op(ALU_DIVU, 32'd9, 32'd0, 33, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0, 1'b1, "div0");
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.gin = ALU_ADD;
    bus.a = 32'd2;
    bus.b = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.a = $urandom;
    @(negedge clk);
    chk("bp_result", bus.result, 32'd5);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_result", bus.result, 32'd5);
      chk("bp_hold_ready", bus.in_ready, 1'b0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(negedge clk);
    chk("b2b_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", bus.out_valid, 1'b1);
    chk("b2b_result", bus.result, 32'd2);
    @(posedge clk);
    #1 bus.in_valid = 1'b1;
    bus.gin = ALU_MUL;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mul_valid", bus.out_valid, 1'b0);
    chk("rst_mul_result", bus.result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.gin = ALU_OR;
    bus.a = 32'h00F0;
    bus.b = 32'h0F00;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_valid", bus.out_valid, 1'b1);
    chk("done_result", bus.result, 32'h0FF0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.in_ready, 1'b1);
    chk("rel_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    op(ALU_SUB, 32'd3, 32'd1, 1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, "sub_after_rst");
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom % 3) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      bus.gin = 3'($urandom);
      bus.a = pick();
      bus.b = pick();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
